// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial sequencer for an external combinational 8:1 bit mux.
// Latency: word accepted at edge E -> first serial bit registered at E+BIT_PERIOD, last at E+8*BIT_PERIOD.
// Backpressure: in_ready only in IDLE or on the final-bit tick, so back-to-back words stream gap-free.
module mux_scan_serializer #(
  parameter int BIT_PERIOD = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mux_data,
  output logic [2:0] mux_sel,
  input  logic       mux_bit,
  output logic       ser_bit,
  output logic       ser_valid,
  output logic       ser_last,
  output logic       busy
);

  // Bit-period counter is at least one bit wide even when BIT_PERIOD is 1.
  localparam int DIV_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_PERIOD - 1);
  localparam logic [2:0]       SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0]       SEL_END   = (MSB_FIRST != 0) ? 3'd0 : 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_mux_data;
  logic [2:0]       r_mux_sel;
  logic             r_ser_bit;
  logic             r_ser_valid;
  logic             r_ser_last;

  logic       w_tick;
  logic       w_at_end;
  logic       w_accept;
  logic [2:0] w_sel_next;

  // End of a select dwell: the mux output is sampled on this edge.
  assign w_tick     = (r_state == SHIFT) && (r_div == DIV_LAST);
  assign w_at_end   = (r_mux_sel == SEL_END);
  // Ready while idle, or on the final tick so the next word reloads with no gap.
  assign in_ready   = (r_state == IDLE) || (w_tick && w_at_end);
  assign w_accept   = in_valid && in_ready;
  assign w_sel_next = (MSB_FIRST != 0) ? (r_mux_sel - 3'd1) : (r_mux_sel + 3'd1);

  // Sequencer: load a word, dwell BIT_PERIOD cycles per select, sample, step, finish or reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_mux_data  <= 8'd0;
      r_mux_sel   <= 3'd0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      // Valid/last are single-cycle pulses; they are only raised on a tick.
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mux_data <= in_data;
            r_mux_sel  <= SEL_START;
            r_div      <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_tick) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_ser_bit   <= mux_bit;
            r_ser_valid <= 1'b1;
            r_ser_last  <= w_at_end;
            r_div       <= '0;
            if (!w_at_end) begin
              r_mux_sel <= w_sel_next;
            end else if (w_accept) begin
              // Back-to-back: the next word replaces the step off the end.
              r_mux_data <= in_data;
              r_mux_sel  <= SEL_START;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mux_data  = r_mux_data;
  assign mux_sel   = r_mux_sel;
  assign ser_bit   = r_ser_bit;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: three instances (LSB/1, MSB/1, LSB/4) each looped through a mux model.
// Reference: every accepted word expands into eight timed expected bits in a queue.
// Inputs are driven 2 time units after the rising edge; outputs are checked on the falling edge.
module tb_mux_scan_serializer;

  localparam int N = 3;

  typedef struct {
    int         edge_no;
    logic       b;
    logic       last;
    logic [2:0] sel;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic [7:0] mux_data  [N];
  logic [2:0] mux_sel   [N];
  logic       mux_bit   [N];
  logic       ser_bit   [N];
  logic       ser_valid [N];
  logic       ser_last  [N];
  logic       busy      [N];

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  exp_t       q [N][$];
  logic       model_ready [N];
  logic [7:0] last_word   [N];
  logic [2:0] idle_sel    [N];
  int         acc_cnt     [N];
  int         acc_edge    [N];
  int         pulses      [N];
  int         last_cnt    [N];
  int         busy_cnt    [N];
  int         rdy_busy    [N];
  int         first_v     [N];
  int         last_v      [N];
  logic [15:0] obs_stream [N];

  function automatic int per(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  function automatic bit msb(input int k);
    return (k == 1);
  endfunction

  mux_scan_serializer #(.BIT_PERIOD(1), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mux_data(mux_data[0]), .mux_sel(mux_sel[0]), .mux_bit(mux_bit[0]), .ser_bit(ser_bit[0]),
    .ser_valid(ser_valid[0]), .ser_last(ser_last[0]), .busy(busy[0]));

  mux_scan_serializer #(.BIT_PERIOD(1), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mux_data(mux_data[1]), .mux_sel(mux_sel[1]), .mux_bit(mux_bit[1]), .ser_bit(ser_bit[1]),
    .ser_valid(ser_valid[1]), .ser_last(ser_last[1]), .busy(busy[1]));

  mux_scan_serializer #(.BIT_PERIOD(4), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .mux_data(mux_data[2]), .mux_sel(mux_sel[2]), .mux_bit(mux_bit[2]), .ser_bit(ser_bit[2]),
    .ser_valid(ser_valid[2]), .ser_last(ser_last[2]), .busy(busy[2]));

  // Behavioural 8:1 mux in the feedback path of each instance.
  assign mux_bit[0] = mux_data[0][mux_sel[0]];
  assign mux_bit[1] = mux_data[1][mux_sel[1]];
  assign mux_bit[2] = mux_data[2][mux_sel[2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h t=%0t", tag, k, obs, exp_v, $time);
    end
  endtask

  // Accept model: a word is taken when the model says the block is ready.
  always @(posedge clk) begin
    exp_t e;
    int s;
    edge_n++;
    for (int k = 0; k < N; k++) begin
      if (!rst && in_valid[k] && model_ready[k]) begin
        for (int i = 0; i < 8; i++) begin
          s = msb(k) ? 7 - i : i;
          e.edge_no = edge_n + (i + 1) * per(k);
          e.sel     = 3'(s);
          e.b       = in_data[s];
          e.last    = (i == 7);
          q[k].push_back(e);
        end
        last_word[k] = in_data;
        acc_cnt[k]++;
        acc_edge[k] = edge_n;
      end
    end
  end

  // Output monitor: compares every output against the queued expectations.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    logic exp_r;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        q[k].delete();
        last_word[k] = 8'd0;
        idle_sel[k]  = 3'd0;
      end
      exp_v = (q[k].size() > 0) && (q[k][0].edge_no == edge_n);
      chk("ser_valid", k, ser_valid[k], exp_v);
      if (exp_v) begin
        e = q[k].pop_front();
        chk("ser_bit", k, ser_bit[k], e.b);
        chk("ser_last", k, ser_last[k], e.last);
        if (e.last) idle_sel[k] = e.sel;
      end
      if (ser_valid[k] === 1'b1) begin
        if (pulses[k] == 0) first_v[k] = edge_n;
        last_v[k] = edge_n;
        pulses[k]++;
        obs_stream[k] = {obs_stream[k][14:0], ser_bit[k]};
      end
      if (ser_last[k] === 1'b1) last_cnt[k]++;
      if (busy[k] === 1'b1) busy_cnt[k]++;
      if (!rst && in_ready[k] === 1'b1 && busy[k] === 1'b1) rdy_busy[k]++;
      exp_r = (q[k].size() == 0) || (q[k][0].last && q[k][0].edge_no == edge_n + 1);
      chk("in_ready", k, in_ready[k], exp_r);
      chk("busy", k, busy[k], q[k].size() > 0);
      chk("mux_data", k, mux_data[k], last_word[k]);
      chk("mux_sel", k, mux_sel[k], (q[k].size() > 0) ? q[k][0].sel : idle_sel[k]);
      model_ready[k] = exp_r;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_stats();
    for (int k = 0; k < N; k++) begin
      acc_cnt[k] = 0; pulses[k] = 0; last_cnt[k] = 0; busy_cnt[k] = 0;
      rdy_busy[k] = 0; first_v[k] = 0; last_v[k] = 0; obs_stream[k] = 16'd0;
    end
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    while (q[k].size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    step(2);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_data = 8'd0;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 1'b0; model_ready[k] = 1'b1; last_word[k] = 8'd0;
      idle_sel[k] = 3'd0; acc_edge[k] = 0;
    end
    clr_stats();
    step(3);

    // Reset state.
    chk("rst_ser_valid", 0, ser_valid[0], 1'b0);
    chk("rst_ser_bit", 0, ser_bit[0], 1'b0);
    chk("rst_ser_last", 0, ser_last[0], 1'b0);
    chk("rst_mux_data", 0, mux_data[0], 8'd0);
    chk("rst_mux_sel", 0, mux_sel[0], 3'd0);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_in_ready", 0, in_ready[0], 1'b1);
    rst = 1'b0;
    step(2);

    // Single word, LSB-first and MSB-first.
    clr_stats();
    in_data = 8'b10011010;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    step(1);
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    wait_idle(0, 40);
    chk("lsb_stream", 0, obs_stream[0], 16'h0059);
    chk("msb_stream", 1, obs_stream[1], 16'h009A);
    chk("lsb_pulses", 0, pulses[0], 8);
    chk("lsb_last_cnt", 0, last_cnt[0], 1);
    chk("lsb_busy_cycles", 0, busy_cnt[0], 8);
    chk("lsb_idle_ready", 0, in_ready[0], 1'b1);

    // Slow bit period.
    clr_stats();
    in_data = 8'hFF;
    in_valid[2] = 1'b1;
    step(1);
    in_valid[2] = 1'b0;
    wait_idle(2, 80);
    chk("slow_first_gap", 2, first_v[2] - acc_edge[2], 4);
    chk("slow_span", 2, last_v[2] - first_v[2], 28);
    chk("slow_pulses", 2, pulses[2], 8);
    chk("slow_stream", 2, obs_stream[2], 16'h00FF);
    chk("slow_busy_cycles", 2, busy_cnt[2], 32);

    // Back-to-back with in_valid held high.
    clr_stats();
    in_data = 8'hA5;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    step(1);
    in_data = 8'h3C;
    n = 0;
    while (acc_cnt[0] < 2 && n < 20) begin
      step(1);
      n++;
    end
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    wait_idle(0, 40);
    chk("b2b_accepts", 0, acc_cnt[0], 2);
    chk("b2b_stream", 0, obs_stream[0], 16'hA53C);
    chk("b2b_pulses", 0, pulses[0], 16);
    chk("b2b_no_gap", 0, last_v[0] - first_v[0], 15);
    chk("b2b_last_cnt", 0, last_cnt[0], 2);
    chk("b2b_ready_in_shift", 0, rdy_busy[0], 2);

    // Input changes while busy are ignored.
    clr_stats();
    in_data = 8'h5E;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      in_data = 8'($urandom);
      step(1);
    end
    in_data = 8'($urandom);
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    wait_idle(0, 40);
    chk("stable_accepts", 0, acc_cnt[0], 1);
    chk("stable_stream", 0, obs_stream[0], 16'h007A);
    chk("stable_mux_data", 0, mux_data[0], 8'h5E);

    // Randomized traffic on all instances.
    clr_stats();
    for (int c = 0; c < 400; c++) begin
      in_valid[0] = ($urandom_range(0, 3) != 0);
      in_valid[1] = in_valid[0];
      in_valid[2] = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      step(1);
    end
    for (int k = 0; k < N; k++) in_valid[k] = 1'b0;
    wait_idle(2, 100);
    wait_idle(0, 40);
    for (int k = 0; k < N; k++) begin
      chk("rand_pulses", k, pulses[k], 8 * acc_cnt[k]);
      chk("rand_last_cnt", k, last_cnt[k], acc_cnt[k]);
    end

    // Reset in the middle of a word.
    clr_stats();
    in_data = 8'b10011010;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    step(1);
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    n = 0;
    while (pulses[0] < 3 && n < 20) begin
      step(1);
      n++;
    end
    chk("mid_pulses_before_rst", 0, pulses[0], 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 0, busy[0], 1'b0);
    chk("mid_rst_mux_data", 0, mux_data[0], 8'd0);
    chk("mid_rst_mux_sel", 0, mux_sel[0], 3'd0);
    chk("mid_rst_ser_bit", 0, ser_bit[0], 1'b0);
    chk("mid_rst_ser_valid", 0, ser_valid[0], 1'b0);
    chk("mid_rst_ser_last", 0, ser_last[0], 1'b0);
    step(1);
    rst = 1'b0;
    step(12);
    chk("mid_post_ready", 0, in_ready[0], 1'b1);
    chk("mid_no_last", 0, last_cnt[0], 0);
    chk("mid_pulses_total", 0, pulses[0], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Upstream sequencer for the 8:1 bit mux (`muxi`). It accepts 8-bit words over a valid/ready handshake and holds each accepted word on the mux data inputs. It then steps the mux select through all 8 positions and registers the mux output bit at each position. The result is an 8-bit serial stream with per-bit valid and last-bit flags, so the mux becomes a parallel-to-serial converter.

Parameters:
BIT_PERIOD, 1, clocks per serial bit; legal range 1..256; the select advances once per BIT_PERIOD cycles.
MSB_FIRST, 0, scan order: 0 gives sel 0→7 (LSB first), 1 gives sel 7→0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  8  parallel word to serialize.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a word this cycle (combinational from state).
mux_data  output  8  registered word driven to the mux data input.
mux_sel  output  3  registered select driven to the mux sel input.
mux_bit  input  1  mux data_o, combinational feedback from the mux.
ser_bit  output  1  registered serial bit.
ser_valid  output  1  one-cycle pulse: ser_bit is valid.
ser_last  output  1  high together with ser_valid on the 8th bit of a word.
busy  output  1  high while in SHIFT.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE;
  - mux_data=0, mux_sel=0;
  - div=0;
  - ser_bit=0, ser_valid=0, ser_last=0.
- Outputs are held at reset values while rst is asserted. Reset mid-word discards the word with no ser_last; the first edge after deassertion runs from IDLE.
- Definitions:
  - START = MSB_FIRST ? 7 : 0
  - END = MSB_FIRST ? 0 : 7
  - div is a bit-period counter of width max(1, clog2(BIT_PERIOD)).
  - tick = (state==SHIFT) && (div==BIT_PERIOD-1)
- in_ready = (state==IDLE) || (tick && mux_sel==END).
- A word is accepted on any edge where in_valid && in_ready.
- On accept:
  - mux_data <= in_data;
  - mux_sel <= START;
  - div <= 0;
  - state <= SHIFT.
- State IDLE:
  - busy=0; mux_data and mux_sel hold their last values.
  - in_valid=0 → stay in IDLE.
  - Accept → go to SHIFT.
- State SHIFT:
  - busy=1.
  - When tick is 0: div increments.
  - When tick is 1:
    - ser_bit <= mux_bit; ser_valid <= 1; ser_last <= (mux_sel==END); div <= 0.
    - If mux_sel≠END: mux_sel steps by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
    - If mux_sel==END and a word is accepted on the same edge: reload and stay in SHIFT. This gives back-to-back streaming with no gap.
    - If mux_sel==END and no word is accepted: go to IDLE.
- ser_valid and ser_last are 0 on every edge without a tick.
- Latency:
  - Word accepted at edge E → first ser_valid is high in the cycle after edge E+BIT_PERIOD.
  - Last bit is registered at edge E+8·BIT_PERIOD.
  - With BIT_PERIOD=1, back-to-back words produce ser_valid high continuously.
- Sampling happens at the end of each select dwell. The mux is combinational, so mux_bit reflects mux_data[mux_sel] at the sampling edge.
- mux_sel never wraps within a word: the step from END is replaced by reload or by the transition to IDLE.
- in_data changes while in SHIFT have no effect; only the accepted value is used.
- in_valid held high in IDLE is accepted on the first edge.

Test Plan:
- Reset mid-stream:
  - Stimulus: MSB_FIRST=0, BIT_PERIOD=1; load 8'b10011010; after 3 ser_valid pulses, assert rst asynchronously between edges.
  - Response: all outputs go to 0 immediately; state=IDLE; in_ready=1 after deassertion; no ser_last is seen.
- LSB-first single word:
  - Stimulus: MSB_FIRST=0, BIT_PERIOD=1; one-cycle in_valid with 8'b10011010.
  - Response: mux_sel steps 0..7; ser_bit sequence 0,1,0,1,1,0,0,1 on 8 consecutive ser_valid cycles; ser_last only on the 8th; busy high for 8 cycles; then in_ready=1.
- MSB-first order:
  - Stimulus: MSB_FIRST=1; same word 8'b10011010.
  - Response: mux_sel steps 7→0; ser_bit sequence 1,0,0,1,1,0,1,0.
- Slow period:
  - Stimulus: BIT_PERIOD=4; word 8'hFF.
  - Response: ser_valid pulses every 4 cycles; the first pulse is visible 4 edges after accept; 8 pulses total; each mux_sel value is held for 4 cycles.
- Back-to-back:
  - Stimulus: BIT_PERIOD=1; in_valid held high with 8'hA5, then 8'h3C presented when in_ready rises.
  - Response: 16 consecutive ser_valid cycles with no gap; bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; ser_last on the 8th and 16th pulses; in_ready high only on the two END edges.
- Input stability while busy:
  - Stimulus: change in_data every cycle during SHIFT, with in_valid=1.
  - Response: mux_data is unchanged until the END tick; the stream matches the originally accepted word.
